// File: rtl/reservation_station.sv
// reservation_station: ALU reservation station with CDB wakeup and lowest-index issue; RS_PERF_CNT_EN adds perf counters
module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 5,
  parameter int OP_W     = 6,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_signal,
  input  logic                ena_rs,
  input  logic [ROB_ID_W-1:0] rd_alias_in,
  input  logic [OP_W-1:0]     optype_in,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   imm_in,
  input  logic [ROB_ID_W-1:0] Qi_in,
  input  logic [ROB_ID_W-1:0] Qj_in,
  input  logic [DATA_W-1:0]   Vi_in,
  input  logic [DATA_W-1:0]   Vj_in,
  output logic                rs_full,
  input  logic                alu_has_result,
  input  logic [ROB_ID_W-1:0] alias_from_alu,
  input  logic [DATA_W-1:0]   result_from_alu,
  input  logic                lsb_has_result,
  input  logic [ROB_ID_W-1:0] alias_from_lsb,
  input  logic [DATA_W-1:0]   result_from_lsb,
  output logic                alu_ena,
  output logic [OP_W-1:0]     alu_optype,
  output logic [ROB_ID_W-1:0] alu_rd_alias,
  output logic [DATA_W-1:0]   alu_pc,
  output logic [DATA_W-1:0]   alu_imm,
  output logic [DATA_W-1:0]   alu_Vi,
  output logic [DATA_W-1:0]   alu_Vj
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_full_cycles
`endif
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy;
  logic [OP_W-1:0]     op  [RS_SIZE];
  logic [ROB_ID_W-1:0] rd  [RS_SIZE];
  logic [ROB_ID_W-1:0] qi  [RS_SIZE];
  logic [ROB_ID_W-1:0] qj  [RS_SIZE];
  logic [DATA_W-1:0]   pc  [RS_SIZE];
  logic [DATA_W-1:0]   imm [RS_SIZE];
  logic [DATA_W-1:0]   vi  [RS_SIZE];
  logic [DATA_W-1:0]   vj  [RS_SIZE];
  logic [IW-1:0] ins_idx, iss_idx;
  logic          has_free, has_rdy;
  logic [IW:0]   n_busy;
  function automatic logic hit(input logic [ROB_ID_W-1:0] q);
    return q != '0 && ((lsb_has_result && q == alias_from_lsb) || (alu_has_result && q == alias_from_alu));
  endfunction
  function automatic logic [DATA_W-1:0] fwd(input logic [ROB_ID_W-1:0] q, input logic [DATA_W-1:0] v);
    return (q != '0 && lsb_has_result && q == alias_from_lsb) ? result_from_lsb :
           (q != '0 && alu_has_result && q == alias_from_alu) ? result_from_alu : v;
  endfunction
  // descending scan so the lowest index wins both encoders
  always_comb begin
    ins_idx  = '0;
    iss_idx  = '0;
    has_free = 1'b0;
    has_rdy  = 1'b0;
    n_busy   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      n_busy = n_busy + (IW+1)'(busy[i]);
      if (!busy[i]) begin
        ins_idx  = IW'(i);
        has_free = 1'b1;
      end
      if (busy[i] && qi[i] == '0 && qj[i] == '0) begin
        iss_idx = IW'(i);
        has_rdy = 1'b1;
      end
    end
  end
  // one slot of slack for the instruction already registered in the dispatcher
  assign rs_full = n_busy >= (IW+1)'(RS_SIZE - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      alu_ena      <= 1'b0;
      alu_optype   <= '0;
      alu_rd_alias <= '0;
      alu_pc       <= '0;
      alu_imm      <= '0;
      alu_Vi       <= '0;
      alu_Vj       <= '0;
    end else if (rollback_signal) begin
      busy    <= '0;
      alu_ena <= 1'b0;
    end else if (!rdy) begin
      alu_ena <= 1'b0;
    end else begin
      alu_ena <= has_rdy;
      if (has_rdy) begin
        alu_optype     <= op[iss_idx];
        alu_rd_alias   <= rd[iss_idx];
        alu_pc         <= pc[iss_idx];
        alu_imm        <= imm[iss_idx];
        alu_Vi         <= vi[iss_idx];
        alu_Vj         <= vj[iss_idx];
        busy[iss_idx]  <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          vi[i] <= fwd(qi[i], vi[i]);
          vj[i] <= fwd(qj[i], vj[i]);
          qi[i] <= hit(qi[i]) ? '0 : qi[i];
          qj[i] <= hit(qj[i]) ? '0 : qj[i];
        end
      end
      if (ena_rs && has_free) begin
        busy[ins_idx] <= 1'b1;
        op[ins_idx]   <= optype_in;
        rd[ins_idx]   <= rd_alias_in;
        pc[ins_idx]   <= pc_in;
        imm[ins_idx]  <= imm_in;
        vi[ins_idx]   <= fwd(Qi_in, Vi_in);
        vj[ins_idx]   <= fwd(Qj_in, Vj_in);
        qi[ins_idx]   <= hit(Qi_in) ? '0 : Qi_in;
        qj[ins_idx]   <= hit(Qj_in) ? '0 : Qj_in;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(rdy && !rollback_signal && ena_rs && !has_free));
`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued      <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_issued      <= perf_issued + 32'(alu_ena);
      perf_full_cycles <= perf_full_cycles + 32'(rdy && rs_full);
    end
  end
`endif
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic against an entry-list reference model
module tb_reservation_station;
  localparam int N = 16;
  logic clk = 0, rst = 1, rdy = 1, rollback_signal = 0, ena_rs = 0;
  logic [4:0]  rd_alias_in = 0, Qi_in = 0, Qj_in = 0, alias_from_alu = 0, alias_from_lsb = 0;
  logic [5:0]  optype_in = 0;
  logic [31:0] pc_in = 0, imm_in = 0, Vi_in = 0, Vj_in = 0, result_from_alu = 0, result_from_lsb = 0;
  logic        alu_has_result = 0, lsb_has_result = 0;
  logic        rs_full, alu_ena;
  logic [5:0]  alu_optype;
  logic [4:0]  alu_rd_alias;
  logic [31:0] alu_pc, alu_imm, alu_Vi, alu_Vj;
`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_issued, perf_full_cycles;
`endif
  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal), .ena_rs(ena_rs),
    .rd_alias_in(rd_alias_in), .optype_in(optype_in), .pc_in(pc_in), .imm_in(imm_in),
    .Qi_in(Qi_in), .Qj_in(Qj_in), .Vi_in(Vi_in), .Vj_in(Vj_in), .rs_full(rs_full),
    .alu_has_result(alu_has_result), .alias_from_alu(alias_from_alu), .result_from_alu(result_from_alu),
    .lsb_has_result(lsb_has_result), .alias_from_lsb(alias_from_lsb), .result_from_lsb(result_from_lsb),
    .alu_ena(alu_ena), .alu_optype(alu_optype), .alu_rd_alias(alu_rd_alias), .alu_pc(alu_pc),
    .alu_imm(alu_imm), .alu_Vi(alu_Vi), .alu_Vj(alu_Vj)
`ifdef RS_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_full_cycles(perf_full_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    bit busy;
    logic [4:0] qi, qj, rd;
    logic [5:0] op;
    logic [31:0] vi, vj, pc, imm;
  } ent_t;
  ent_t m[N];
  bit m_ena;
  logic [5:0] m_op;
  logic [4:0] m_rd;
  logic [31:0] m_pc, m_imm, m_vi, m_vj;
  int e_iss, e_full;
  int tests = 0, fails = 0;
  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m[i].busy);
    return c;
  endfunction
  function automatic bit on_bus(input logic [4:0] q, output logic [31:0] d);
    d = 0;
    if (q == 0) return 0;
    if (lsb_has_result && alias_from_lsb == q) begin d = result_from_lsb; return 1; end
    if (alu_has_result && alias_from_alu == q) begin d = result_from_alu; return 1; end
    return 0;
  endfunction
  // advance model by one edge using the inputs currently applied, then clock the DUT
  task automatic step();
    int iss = -1, ins = -1;
    logic [31:0] d;
    if (rst) begin e_iss = 0; e_full = 0; end
    else begin e_iss += int'(m_ena); if (rdy && m_count() >= N - 1) e_full++; end
    if (rst || rollback_signal) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_ena = 0;
      if (rst) begin m_op = 0; m_rd = 0; m_pc = 0; m_imm = 0; m_vi = 0; m_vj = 0; end
    end else if (!rdy) m_ena = 0;
    else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m[i].busy && m[i].qi == 0 && m[i].qj == 0) iss = i;
        if (!m[i].busy) ins = i;
      end
      m_ena = iss >= 0;
      if (iss >= 0) begin
        m_op = m[iss].op; m_rd = m[iss].rd; m_pc = m[iss].pc; m_imm = m[iss].imm;
        m_vi = m[iss].vi; m_vj = m[iss].vj;
      end
      for (int i = 0; i < N; i++) if (m[i].busy) begin
        if (on_bus(m[i].qi, d)) begin m[i].qi = 0; m[i].vi = d; end
        if (on_bus(m[i].qj, d)) begin m[i].qj = 0; m[i].vj = d; end
      end
      if (iss >= 0) m[iss].busy = 0;
      if (ena_rs && ins >= 0) begin
        m[ins].busy = 1; m[ins].op = optype_in; m[ins].rd = rd_alias_in;
        m[ins].pc = pc_in; m[ins].imm = imm_in;
        m[ins].qi = Qi_in; m[ins].vi = Vi_in; m[ins].qj = Qj_in; m[ins].vj = Vj_in;
        if (on_bus(Qi_in, d)) begin m[ins].qi = 0; m[ins].vi = d; end
        if (on_bus(Qj_in, d)) begin m[ins].qj = 0; m[ins].vj = d; end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ena_rs = 0; alu_has_result = 0; lsb_has_result = 0; rollback_signal = 0; rdy = 1;
  endtask
  task automatic put(input logic [4:0] qi, input logic [31:0] vi, input logic [4:0] qj,
                     input logic [31:0] vj, input logic [4:0] rd);
    ena_rs = 1; Qi_in = qi; Vi_in = vi; Qj_in = qj; Vj_in = vj; rd_alias_in = rd;
    optype_in = 6'(rd) ^ 6'h2a; pc_in = 32'h1000 + 32'(rd); imm_in = 32'hff00 | 32'(rd);
  endtask
  task automatic apply_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask
  task automatic test_reset();
    apply_reset();
    tests++;
    if (alu_ena !== 1'b0 || rs_full !== 1'b0) begin
      fails++; $display("FAIL reset_flags alu_ena=%b rs_full=%b expected 0 0", alu_ena, rs_full);
    end
    tests++;
    if (alu_Vi !== 0 || alu_Vj !== 0 || alu_rd_alias !== 0 || alu_optype !== 0 || alu_pc !== 0 || alu_imm !== 0) begin
      fails++; $display("FAIL reset_payload Vi=%h Vj=%h rd=%0d op=%0d expected all 0", alu_Vi, alu_Vj, alu_rd_alias, alu_optype);
    end
  endtask
  task automatic test_basic_issue();
    apply_reset();
    put(0, 5, 0, 7, 3); step(); idle();
    tests++;
    if (alu_ena !== 1'b0) begin fails++; $display("FAIL basic_gap alu_ena=%b expected 0", alu_ena); end
    step();
    tests++;
    if (alu_ena !== 1'b1 || alu_Vi !== 32'd5 || alu_Vj !== 32'd7 || alu_rd_alias !== 5'd3) begin
      fails++; $display("FAIL basic_issue ena=%b Vi=%0h Vj=%0h rd=%0d expected 1 5 7 3", alu_ena, alu_Vi, alu_Vj, alu_rd_alias);
    end
    step();
    tests++;
    if (alu_ena !== 1'b0 || alu_Vi !== 32'd5) begin
      fails++; $display("FAIL basic_freed ena=%b Vi=%0h expected 0 5", alu_ena, alu_Vi);
    end
  endtask
  task automatic test_wakeup();
    apply_reset();
    put(4, 0, 0, 32'h11, 8); step(); idle();
    repeat (3) step();
    alu_has_result = 1; alias_from_alu = 4; result_from_alu = 32'h1234; step(); idle();
    tests++;
    if (alu_ena !== 1'b0) begin fails++; $display("FAIL wake_gap alu_ena=%b expected 0", alu_ena); end
    step();
    tests++;
    if (alu_ena !== 1'b1 || alu_Vi !== 32'h1234 || alu_Vj !== 32'h11 || alu_rd_alias !== 5'd8) begin
      fails++; $display("FAIL wake_issue ena=%b Vi=%h Vj=%h rd=%0d expected 1 1234 11 8", alu_ena, alu_Vi, alu_Vj, alu_rd_alias);
    end
  endtask
  task automatic test_bypass();
    apply_reset();
    put(6, 0, 0, 32'h22, 12); lsb_has_result = 1; alias_from_lsb = 6; result_from_lsb = 9; step(); idle();
    step();
    tests++;
    if (alu_ena !== 1'b1 || alu_Vi !== 32'd9 || alu_rd_alias !== 5'd12) begin
      fails++; $display("FAIL bypass_issue ena=%b Vi=%0h rd=%0d expected 1 9 12", alu_ena, alu_Vi, alu_rd_alias);
    end
  endtask
  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 15; k++) begin put(2, 0, 0, 32'(k), 5'(k + 1)); step(); end
    idle();
    tests++;
    if (rs_full !== 1'b1) begin fails++; $display("FAIL full_set rs_full=%b expected 1", rs_full); end
    alu_has_result = 1; alias_from_alu = 2; result_from_alu = 32'h100; step(); idle();
    tests++;
    if (alu_ena !== 1'b0) begin fails++; $display("FAIL full_wake_gap alu_ena=%b expected 0", alu_ena); end
    for (int k = 0; k < 15; k++) begin
      step();
      tests++;
      if (alu_ena !== 1'b1 || alu_rd_alias !== 5'(k + 1) || alu_Vi !== 32'h100 || alu_Vj !== 32'(k)) begin
        fails++; $display("FAIL full_drain_%0d ena=%b rd=%0d Vi=%h expected 1 %0d 100", k, alu_ena, alu_rd_alias, alu_Vi, k + 1);
      end
      if (k == 0) begin
        tests++;
        if (rs_full !== 1'b0) begin fails++; $display("FAIL full_drop rs_full=%b expected 0", rs_full); end
      end
    end
    step();
    tests++;
    if (alu_ena !== 1'b0) begin fails++; $display("FAIL full_empty alu_ena=%b expected 0", alu_ena); end
  endtask
  task automatic test_rollback();
    apply_reset();
    put(0, 1, 0, 2, 30); step();
    for (int k = 0; k < 7; k++) begin put(3, 0, 0, 0, 5'(k + 1)); step(); end
    idle(); rollback_signal = 1; step(); idle();
    tests++;
    if (alu_ena !== 1'b0 || rs_full !== 1'b0 || alu_rd_alias !== 5'd30) begin
      fails++; $display("FAIL rollback_flush ena=%b full=%b rd=%0d expected 0 0 30", alu_ena, rs_full, alu_rd_alias);
    end
    alu_has_result = 1; alias_from_alu = 3; result_from_alu = 32'hdead; step(); idle();
    repeat (2) begin
      step();
      tests++;
      if (alu_ena !== 1'b0) begin fails++; $display("FAIL rollback_ghost alu_ena=%b expected 0", alu_ena); end
    end
  endtask
  task automatic test_pause();
    apply_reset();
    put(5, 0, 0, 1, 20); step();
    put(0, 32'h55, 0, 2, 9); step(); idle();
    rdy = 0; alu_has_result = 1; alias_from_alu = 5; result_from_alu = 32'h77;
    for (int k = 0; k < 3; k++) begin
      step(); alu_has_result = 0;
      tests++;
      if (alu_ena !== 1'b0) begin fails++; $display("FAIL pause_%0d alu_ena=%b expected 0", k, alu_ena); end
    end
    rdy = 1; step();
    tests++;
    if (alu_ena !== 1'b1 || alu_rd_alias !== 5'd9 || alu_Vi !== 32'h55) begin
      fails++; $display("FAIL pause_resume ena=%b rd=%0d Vi=%h expected 1 9 55", alu_ena, alu_rd_alias, alu_Vi);
    end
    step();
    tests++;
    if (alu_ena !== 1'b0) begin fails++; $display("FAIL pause_nocapture alu_ena=%b expected 0", alu_ena); end
    alu_has_result = 1; alias_from_alu = 5; result_from_alu = 32'h88; step(); idle(); step();
    tests++;
    if (alu_ena !== 1'b1 || alu_Vi !== 32'h88 || alu_rd_alias !== 5'd20) begin
      fails++; $display("FAIL pause_late_wake ena=%b Vi=%h rd=%0d expected 1 88 20", alu_ena, alu_Vi, alu_rd_alias);
    end
`ifdef RS_PERF_CNT_EN
    step();
    tests++;
    if (perf_issued !== 32'(e_iss)) begin fails++; $display("FAIL perf_issued got=%0d expected %0d", perf_issued, e_iss); end
`endif
  endtask
  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rdy = $urandom_range(0, 9) != 0;
      rollback_signal = $urandom_range(0, 59) == 0;
      alu_has_result = $urandom_range(0, 2) == 0;
      alias_from_alu = 5'($urandom_range(0, 7));
      result_from_alu = $urandom;
      lsb_has_result = $urandom_range(0, 3) == 0;
      alias_from_lsb = 5'($urandom_range(0, 7));
      result_from_lsb = $urandom;
      if (alu_has_result && lsb_has_result && alias_from_alu == alias_from_lsb)
        alias_from_lsb = (alias_from_alu % 7) + 1;
      ena_rs = $urandom_range(0, 1) == 1 && m_count() < N;
      Qi_in = $urandom_range(0, 2) == 0 ? 5'd0 : 5'($urandom_range(1, 7));
      Qj_in = $urandom_range(0, 2) == 0 ? 5'd0 : 5'($urandom_range(1, 7));
      Vi_in = $urandom; Vj_in = $urandom; pc_in = $urandom; imm_in = $urandom;
      rd_alias_in = 5'($urandom); optype_in = 6'($urandom);
      step();
      tests++;
      if (alu_ena !== m_ena) begin fails++; $display("FAIL rand_ena cyc=%0d got=%b expected %b", c, alu_ena, m_ena); end
      tests++;
      if (alu_optype !== m_op || alu_rd_alias !== m_rd || alu_pc !== m_pc || alu_imm !== m_imm || alu_Vi !== m_vi || alu_Vj !== m_vj) begin
        fails++; $display("FAIL rand_payload cyc=%0d rd=%0d Vi=%h Vj=%h expected rd=%0d Vi=%h Vj=%h", c, alu_rd_alias, alu_Vi, alu_Vj, m_rd, m_vi, m_vj);
      end
      tests++;
      if (rs_full !== (m_count() >= N - 1)) begin fails++; $display("FAIL rand_full cyc=%0d got=%b count=%0d", c, rs_full, m_count()); end
    end
    idle();
`ifdef RS_PERF_CNT_EN
    tests++;
    if (perf_issued !== 32'(e_iss) || perf_full_cycles !== 32'(e_full)) begin
      fails++; $display("FAIL rand_perf issued=%0d full=%0d expected %0d %0d", perf_issued, perf_full_cycles, e_iss, e_full);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_full();
    test_rollback();
    test_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
